// File: rtl/ro_puf_ctrl.sv
// ---------------------------------------------------------------------------
// ro_puf_ctrl -- measurement sequencer for the weak RO PUF array.
//
// Steps through the RO pairs one at a time. For each pair it clears the
// shared edge counters, warms up the ROs, gates the counters for a fixed
// window, lets the counter synchronisers drain, then compares the two counts.
// The results are assembled into a response word. That word is offered over a
// valid/ready handshake.
//
// Optional feature: define RO_PUF_MAJORITY_VOTE_EN to measure every pair
// VOTES times and keep the majority result. Without the macro there is one
// measurement per pair, and no vote logic is built.
//
// Ports:
//   clk_ref       in   reference clock (only clock)
//   rst           in   synchronous reset, active-high
//   start         in   request a full evaluation (honoured only in IDLE)
//   busy          out  high in every state except IDLE
//   pair_sel      out  index of the RO pair routed to the counters
//   ro_en         out  enable for both ROs of the selected pair (registered)
//   cnt_clr       out  synchronous clear for both counters (registered)
//   cnt_gate      out  count enable for both counters (registered)
//   count_a/b     in   edge counts of the two ROs of the selected pair
//   puf_response  out  bit i = 1 when RO a of pair i counted more edges
//   tie_mask      out  bit i = 1 when pair i produced equal counts
//   resp_valid    out  response available
//   resp_ready    in   consumer accepts the response
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ro_puf_ctrl #(
    parameter int PAIRS         = 64,
    parameter int CNT_W         = 32,
    parameter int WINDOW_CYCLES = 50000,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_CYCLES   = 4,
    parameter int VOTES         = 3
) (
    input  logic                     clk_ref,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic [$clog2(PAIRS)-1:0] pair_sel,
    output logic                     ro_en,
    output logic                     cnt_clr,
    output logic                     cnt_gate,
    input  logic [CNT_W-1:0]         count_a,
    input  logic [CNT_W-1:0]         count_b,
    output logic [PAIRS-1:0]         puf_response,
    output logic [PAIRS-1:0]         tie_mask,
    output logic                     resp_valid,
    input  logic                     resp_ready
);

    localparam int SEL_W   = $clog2(PAIRS);
    localparam int PH_MAX0 = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > SYNC_CYCLES) ? PH_MAX0 : SYNC_CYCLES;
    // The phase counter is loaded with (duration - 1) and counts down to zero.
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  WINDOW_LD = PH_W'(WINDOW_CYCLES - 1);
    localparam logic [PH_W-1:0]  SYNC_LD   = PH_W'(SYNC_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_PAIR = SEL_W'(PAIRS - 1);

    if (PAIRS < 2 || (PAIRS & (PAIRS - 1)) != 0 || WINDOW_CYCLES < 1 ||
        SETTLE_CYCLES < 1 || SYNC_CYCLES < 1 || VOTES < 1 || (VOTES % 2) == 0)
    begin : g_bad_params
        $error("ro_puf_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARMUP,
        S_GATE,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [PAIRS-1:0]   resp_q, resp_d;
    logic [PAIRS-1:0]   tie_q, tie_d;
    logic               busy_q, ro_en_q, clr_q, gate_q, valid_q;
    logic               phase_done, last_pair, a_gt_b, a_eq_b;

    assign phase_done = (phase_q == '0);
    assign last_pair  = (sel_q == LAST_PAIR);
    assign a_gt_b     = (count_a > count_b);
    assign a_eq_b     = (count_a == count_b);

`ifdef RO_PUF_MAJORITY_VOTE_EN
    localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int OW = $clog2(VOTES + 1);
    localparam logic [VW-1:0] LAST_VOTE = VW'(VOTES - 1);
    localparam logic [OW-1:0] HALF      = OW'(VOTES / 2);

    logic [VW-1:0] vote_q, vote_d;
    logic [OW-1:0] ones_q, ones_d, ones_new;
    logic          vtie_q, vtie_d, tie_new;

    // Tallies that include the comparison being made in this COMPARE cycle.
    assign ones_new = ones_q + OW'(a_gt_b);
    assign tie_new  = vtie_q | a_eq_b;
`endif

    // NOTE: every signal driven here gets its default first, so no path
    // through the case statement can leave one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sel_d   = sel_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
`ifdef RO_PUF_MAJORITY_VOTE_EN
        vote_d  = vote_q;
        ones_d  = ones_q;
        vtie_d  = vtie_q;
`endif
        case (state_q)
            S_IDLE: begin
                sel_d = '0;
                if (start) begin
                    resp_d  = '0;
                    tie_d   = '0;
                    state_d = S_CLEAR;
`ifdef RO_PUF_MAJORITY_VOTE_EN
                    vote_d  = '0;
                    ones_d  = '0;
                    vtie_d  = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                state_d = S_WARMUP;
                phase_d = SETTLE_LD;
            end
            S_WARMUP: begin
                if (phase_done) begin
                    state_d = S_GATE;
                    phase_d = WINDOW_LD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_GATE: begin
                if (phase_done) begin
                    state_d = S_DRAIN;
                    phase_d = SYNC_LD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (phase_done) begin
                    state_d = S_COMPARE;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_COMPARE: begin
`ifdef RO_PUF_MAJORITY_VOTE_EN
                if (vote_q != LAST_VOTE) begin
                    // Re-measure the same pair.
                    vote_d  = vote_q + 1'b1;
                    ones_d  = ones_new;
                    vtie_d  = tie_new;
                    state_d = S_CLEAR;
                end else begin
                    resp_d[sel_q] = (ones_new > HALF);
                    tie_d[sel_q]  = tie_new;
                    vote_d        = '0;
                    ones_d        = '0;
                    vtie_d        = 1'b0;
                    if (last_pair) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        state_d = S_CLEAR;
                    end
                end
`else
                // A tie leaves the response bit at 0 and is flagged separately.
                resp_d[sel_q] = a_gt_b;
                tie_d[sel_q]  = a_eq_b;
                if (last_pair) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    state_d = S_CLEAR;
                end
`endif
            end
            S_DONE: begin
                // resp_valid is high for the whole time the FSM is in DONE.
                if (resp_ready) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only. The datapath
    // controls are decoded from the next state and then registered. This keeps
    // them glitch-free and aligned with the state they belong to.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            sel_q   <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
            busy_q  <= 1'b0;
            ro_en_q <= 1'b0;
            clr_q   <= 1'b0;
            gate_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef RO_PUF_MAJORITY_VOTE_EN
            vote_q  <= '0;
            ones_q  <= '0;
            vtie_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            busy_q  <= (state_d != S_IDLE);
            ro_en_q <= (state_d == S_CLEAR) || (state_d == S_WARMUP) || (state_d == S_GATE);
            clr_q   <= (state_d == S_CLEAR);
            gate_q  <= (state_d == S_GATE);
            valid_q <= (state_d == S_DONE);
`ifdef RO_PUF_MAJORITY_VOTE_EN
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            vtie_q  <= vtie_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign pair_sel     = sel_q;
    assign ro_en        = ro_en_q;
    assign cnt_clr      = clr_q;
    assign cnt_gate     = gate_q;
    assign puf_response = resp_q;
    assign tie_mask     = tie_q;
    assign resp_valid   = valid_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_ctrl -- directed self-checking bench for ro_puf_ctrl.
// The counter datapath is modelled from ro_en/cnt_clr/cnt_gate. Each gated
// cycle adds 3 to a count, capped at the target value for that measurement.
// Each measurement lasts 8 gated cycles, so any target up to 24 is reached
// exactly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ro_puf_ctrl;

    localparam int PAIRS = 4;
    localparam int CNT_W = 8;
    localparam int WIN   = 8;
    localparam int SET   = 2;
    localparam int SYN   = 2;
    localparam int VOTES = 3;
`ifdef RO_PUF_MAJORITY_VOTE_EN
    localparam int NV = VOTES;
`else
    localparam int NV = 1;
`endif
    localparam int MEAS_CYC = WIN + SET + SYN + 2;   // 14
    localparam int NMEAS    = PAIRS * NV;

    logic             clk_ref    = 1'b0;
    logic             rst        = 1'b1;
    logic             start      = 1'b0;
    logic             resp_ready = 1'b0;
    logic             busy, ro_en, cnt_clr, cnt_gate, resp_valid;
    logic [1:0]       pair_sel;
    logic [CNT_W-1:0] count_a, count_b;
    logic [PAIRS-1:0] puf_response, tie_mask;

    logic [CNT_W-1:0] tgt_a [NMEAS];
    logic [CNT_W-1:0] tgt_b [NMEAS];
    logic             model_rst  = 1'b0;
    logic             gate_wo_en = 1'b0;
    int               clr_seen   = 0;
    int               cyc        = 0;
    int               midx;
    int               n_err      = 0;
    int               n_chk      = 0;

    ro_puf_ctrl #(
        .PAIRS(PAIRS), .CNT_W(CNT_W), .WINDOW_CYCLES(WIN),
        .SETTLE_CYCLES(SET), .SYNC_CYCLES(SYN), .VOTES(VOTES)
    ) dut (
        .clk_ref(clk_ref), .rst(rst), .start(start), .busy(busy),
        .pair_sel(pair_sel), .ro_en(ro_en), .cnt_clr(cnt_clr),
        .cnt_gate(cnt_gate), .count_a(count_a), .count_b(count_b),
        .puf_response(puf_response), .tie_mask(tie_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    always #5 clk_ref = ~clk_ref;

    always @(posedge clk_ref) cyc <= cyc + 1;

    // Counter datapath model.
    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] c,
                                              input logic [CNT_W-1:0] t);
        return (int'(c) + 3 >= int'(t)) ? t : c + CNT_W'(3);
    endfunction

    assign midx = (clr_seen > 0) ? (clr_seen - 1) % NMEAS : 0;

    always @(posedge clk_ref) begin
        if (model_rst)    clr_seen <= 0;
        else if (cnt_clr) clr_seen <= clr_seen + 1;
        if (cnt_clr) begin
            count_a <= '0;
            count_b <= '0;
        end else if (cnt_gate && ro_en) begin
            count_a <= step(count_a, tgt_a[midx]);
            count_b <= step(count_b, tgt_b[midx]);
        end
    end

    always @(negedge clk_ref) if (cnt_gate && !ro_en) gate_wo_en <= 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_ref);
    endtask

    // Packed arguments: pair 0 in the low byte. Every vote gets the same counts.
    task automatic set_pairs(input logic [4*CNT_W-1:0] av, input logic [4*CNT_W-1:0] bv);
        for (int p = 0; p < PAIRS; p++)
            for (int v = 0; v < NV; v++) begin
                tgt_a[p*NV+v] = av[p*CNT_W +: CNT_W];
                tgt_b[p*NV+v] = bv[p*CNT_W +: CNT_W];
            end
    endtask

    // Returns at the negedge of the CLEAR cycle for pair 0.
    task automatic pulse_start();
        start     = 1'b1;
        model_rst = 1'b1;
        tick();
        start     = 1'b0;
        model_rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int t);
        int n;
        n = 0;
        while (!resp_valid && n < 2000) begin
            tick();
            n++;
        end
        check(tag, resp_valid, 1'b1);
        t = cyc;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, pair_sel, ro_en, cnt_clr, cnt_gate, resp_valid,
                    puf_response, tie_mask}, '0);
    endtask

    initial begin
        int          t_clr, t_v, n;
        logic [14:0] clr_v, en_v, gate_v;
        logic [1:0]  sel13, sel14;
        logic        stable;

        // Reset state.
        repeat (3) tick();
        check_zero("reset_outputs");
        rst = 1'b0;
        tick();
        check_zero("idle_after_reset");

        // Tests 1+2: full evaluation and phase timing on pair 0.
        set_pairs({8'd20, 8'd7, 8'd3, 8'd10}, {8'd1, 8'd7, 8'd9, 8'd5});
        resp_ready = 1'b1;
        pulse_start();
        t_clr = cyc;
        clr_v = '0; en_v = '0; gate_v = '0; sel13 = '0; sel14 = '0;
        for (int i = 0; i < 15; i++) begin
            clr_v[i]  = cnt_clr;
            en_v[i]   = ro_en;
            gate_v[i] = cnt_gate;
            if (i == 13) sel13 = pair_sel;
            if (i == 14) sel14 = pair_sel;
            tick();
        end
        check("t2_cnt_clr_pattern", clr_v, 15'h4001);
        check("t2_ro_en_pattern", en_v, 15'h47FF);
        check("t2_cnt_gate_pattern", gate_v, 15'h07F8);
        check("t2_sel_in_compare", sel13, 2'd0);
        check("t2_sel_after_compare", sel14, (NV == 1) ? 2'd1 : 2'd0);
        wait_valid("t1_valid_timeout", t_v);
        check("t1_valid_latency", t_v - t_clr, PAIRS * MEAS_CYC * NV);
        check("t1_response", puf_response, 4'b1001);
        check("t1_tie_mask", tie_mask, 4'b0100);
        check("t1_busy_in_done", busy, 1'b1);
        tick();
        check("t1_after_handshake", {busy, resp_valid}, 2'b00);
        check("t1_response_held", puf_response, 4'b1001);

        // Test 3: back-pressure in DONE, and a start pulse that must be ignored.
        resp_ready = 1'b0;
        set_pairs({8'd0, 8'd5, 8'd24, 8'd1}, {8'd0, 8'd5, 8'd23, 8'd2});
        pulse_start();
        wait_valid("t3_valid_timeout", t_v);
        check("t3_response", puf_response, 4'b0010);
        check("t3_tie_mask", tie_mask, 4'b1100);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            if (!resp_valid || puf_response != 4'b0010 || tie_mask != 4'b1100)
                stable = 1'b0;
        end
        check("t3_hold_stable", stable, 1'b1);
        check("t3_still_done", {busy, resp_valid}, 2'b11);
        resp_ready = 1'b1;
        tick();
        check("t3_after_handshake", {busy, resp_valid}, 2'b00);
        check("t3_response_held", puf_response, 4'b0010);
        tick();
        check("t3_no_queued_start", busy, 1'b0);

        // Test 4: reset during GATE of pair 2.
        set_pairs({8'd20, 8'd7, 8'd3, 8'd10}, {8'd1, 8'd7, 8'd9, 8'd5});
        pulse_start();
        n = 0;
        while (!(pair_sel == 2'd2 && cnt_gate) && n < 500) begin
            tick();
            n++;
        end
        check("t4_reach_pair2_gate", (pair_sel == 2'd2) && cnt_gate, 1'b1);
        check("t4_partial_response", puf_response, 4'b0001);
        rst = 1'b1;
        tick();
        check_zero("t4_outputs_after_rst");
        rst = 1'b0;
        tick();
        check_zero("t4_idle_after_rst");
        pulse_start();
        wait_valid("t4_valid_timeout", t_v);
        check("t4_response", puf_response, 4'b1001);
        check("t4_tie_mask", tie_mask, 4'b0100);
        tick();
        check("t4_after_handshake", busy, 1'b0);

        // Test 5: start held high, back-to-back evaluations.
        start     = 1'b1;
        model_rst = 1'b1;
        tick();
        model_rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_valid("t5_valid_timeout", t_v);
            check("t5_response", puf_response, 4'b1001);
            tick();
            check("t5_idle_between_runs", busy, 1'b0);
            tick();
            check("t5_restart_busy_clr", {busy, cnt_clr}, 2'b11);
            check("t5_response_cleared", {puf_response, tie_mask}, 8'h00);
        end
        start = 1'b0;
        wait_valid("t5_last_valid_timeout", t_v);
        tick();
        check("t5_final_idle", busy, 1'b0);

`ifdef RO_PUF_MAJORITY_VOTE_EN
        // Test 6: majority vote. Entries are indexed as pair*3 + vote.
        tgt_a[0] = 8'd10; tgt_b[0] = 8'd5;
        tgt_a[1] = 8'd3;  tgt_b[1] = 8'd9;
        tgt_a[2] = 8'd7;  tgt_b[2] = 8'd2;
        tgt_a[3] = 8'd4;  tgt_b[3] = 8'd4;
        tgt_a[4] = 8'd1;  tgt_b[4] = 8'd6;
        tgt_a[5] = 8'd2;  tgt_b[5] = 8'd8;
        for (int v = 6; v < 9; v++)  begin tgt_a[v] = 8'd9; tgt_b[v] = 8'd1; end
        for (int v = 9; v < 12; v++) begin tgt_a[v] = 8'd1; tgt_b[v] = 8'd9; end
        pulse_start();
        n = 0;
        while (pair_sel != 2'd1 && n < 500) begin
            tick();
            n++;
        end
        check("t6_pair_duration", n, 42);
        wait_valid("t6_valid_timeout", t_v);
        check("t6_response", puf_response, 4'b0101);
        check("t6_tie_mask", tie_mask, 4'b0010);
        tick();
`endif

        check("gate_without_ro_en", gate_wo_en, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
